// File: rtl/block_field_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : block_field_ctrl
// Brief    : Breakout block-field arbiter: grants one kill per contact, drives
//            ball bounces, the shared descent step, score and end-of-game flags.
// Revision : 1.0 - initial release
// ============================================================================
module block_field_ctrl #(
   parameter int N_BLOCKS   = 4,
   parameter int STEP_DIV   = 25000000,
   parameter int COOL_TICKS = 4,
   parameter int POINTS     = 10
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                ball_tick,
   input  logic [N_BLOCKS-1:0] exist,
   input  logic [N_BLOCKS-1:0] hit_u,
   input  logic [N_BLOCKS-1:0] hit_d,
   input  logic [N_BLOCKS-1:0] hit_l,
   input  logic [N_BLOCKS-1:0] hit_r,
   input  logic [N_BLOCKS-1:0] at_bottom,
   output logic [N_BLOCKS-1:0] kill,
   output logic                bounce_x,
   output logic                bounce_y,
   output logic                step_down,
   output logic [15:0]         score,
   output logic [3:0]          blocks_left,
   output logic                level_clear,
   output logic                game_over,
   output logic [2:0]          state
);

   localparam int c_presc_w = $clog2(STEP_DIV);
   localparam int c_cool_w  = $clog2(COOL_TICKS + 1);
   localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(STEP_DIV - 1);
   localparam logic [c_cool_w-1:0]  c_cool_load = c_cool_w'(COOL_TICKS);
   localparam logic [16:0]          c_points    = 17'(POINTS);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RUN      = 3'd1,
      S_HIT      = 3'd2,
      S_COOLDOWN = 3'd3,
      S_CLEAR    = 3'd4,
      S_OVER     = 3'd5
   } state_t;

   state_t                r_state;
   logic [c_presc_w-1:0]  r_presc;
   logic [c_cool_w-1:0]   r_cool;

   logic [N_BLOCKS-1:0]   w_hv;
   logic [N_BLOCKS-1:0]   w_bv;
   logic [N_BLOCKS-1:0]   w_win;
   logic                  w_win_x;
   logic                  w_win_y;
   logic [3:0]            w_count;
   logic [16:0]           w_score_sum;
   logic [15:0]           w_score_next;

   assign w_hv = (hit_u | hit_d | hit_l | hit_r) & exist;
   assign w_bv = at_bottom & exist;

   // Two's-complement trick isolates the lowest set bit: that block wins.
   assign w_win   = w_hv & (~w_hv + N_BLOCKS'(1));
   assign w_win_x = |(w_win & (hit_l | hit_r));
   assign w_win_y = |(w_win & (hit_u | hit_d));

   assign w_score_sum  = {1'b0, score} + c_points;
   assign w_score_next = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];

   always_comb begin
      w_count = 4'd0;
      for (int i = 0; i < N_BLOCKS; i++) begin
         w_count = w_count + 4'(exist[i]);
      end
   end

   assign state = r_state;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_presc     <= '0;
         r_cool      <= '0;
         kill        <= '0;
         bounce_x    <= 1'b0;
         bounce_y    <= 1'b0;
         step_down   <= 1'b0;
         score       <= 16'd0;
         blocks_left <= 4'd0;
         level_clear <= 1'b0;
         game_over   <= 1'b0;
      end else begin
         blocks_left <= w_count;
         kill        <= '0;
         bounce_x    <= 1'b0;
         bounce_y    <= 1'b0;
         step_down   <= 1'b0;

         // Descent timebase only advances while play is live; it keeps its
         // phase across pauses and hits.
         if (r_state == S_RUN) begin
            if (r_presc == c_presc_max) begin
               r_presc   <= '0;
               step_down <= 1'b1;
            end else begin
               r_presc <= r_presc + c_presc_w'(1);
            end
         end

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (exist != '0) begin
                     r_state <= S_RUN;
                  end else begin
                     r_state     <= S_CLEAR;
                     level_clear <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (w_bv != '0) begin
                  r_state   <= S_OVER;
                  game_over <= 1'b1;
               end else if (w_hv != '0) begin
                  // Grant outputs are staged here so they are valid during HIT.
                  r_state  <= S_HIT;
                  kill     <= w_win;
                  bounce_x <= w_win_x;
                  bounce_y <= w_win_y;
                  score    <= w_score_next;
               end else if (exist == '0) begin
                  r_state     <= S_CLEAR;
                  level_clear <= 1'b1;
               end else if (!start) begin
                  r_state <= S_IDLE;
               end
            end
            S_HIT: begin
               r_cool  <= c_cool_load;
               r_state <= S_COOLDOWN;
            end
            S_COOLDOWN: begin
               if (w_bv != '0) begin
                  r_state   <= S_OVER;
                  game_over <= 1'b1;
               end else if (ball_tick) begin
                  if (r_cool == c_cool_w'(1)) begin
                     r_cool  <= '0;
                     r_state <= S_RUN;
                  end else begin
                     r_cool <= r_cool - c_cool_w'(1);
                  end
               end
            end
            S_CLEAR: begin
               level_clear <= 1'b1;
            end
            S_OVER: begin
               game_over <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_block_field_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_field_ctrl
// Brief    : Directed self-checking bench for block_field_ctrl (N=4, STEP_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_block_field_ctrl;

   logic       clock;
   logic       reset;
   logic       start;
   logic       ball_tick;
   logic [3:0] exist;
   logic [3:0] hit_u;
   logic [3:0] hit_d;
   logic [3:0] hit_l;
   logic [3:0] hit_r;
   logic [3:0] at_bottom;
   logic [3:0] kill;
   logic       bounce_x;
   logic       bounce_y;
   logic       step_down;
   logic [15:0] score;
   logic [3:0] blocks_left;
   logic       level_clear;
   logic       game_over;
   logic [2:0] state;

   int n_vec = 0;
   int n_err = 0;

   block_field_ctrl #(
      .N_BLOCKS   (4),
      .STEP_DIV   (4),
      .COOL_TICKS (4),
      .POINTS     (10)
   ) u_dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .ball_tick   (ball_tick),
      .exist       (exist),
      .hit_u       (hit_u),
      .hit_d       (hit_d),
      .hit_l       (hit_l),
      .hit_r       (hit_r),
      .at_bottom   (at_bottom),
      .kill        (kill),
      .bounce_x    (bounce_x),
      .bounce_y    (bounce_y),
      .step_down   (step_down),
      .score       (score),
      .blocks_left (blocks_left),
      .level_clear (level_clear),
      .game_over   (game_over),
      .state       (state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
      $fatal(1);
   end

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_ball();
      ball_tick = 1'b1;
      tick();
      ball_tick = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; ball_tick = 1'b0; exist = 4'hF;
      hit_u = '0; hit_d = '0; hit_l = '0; hit_r = '0; at_bottom = '0;
      tick(); tick();
      check_value("rst_state", 32'(state), 0);
      check_value("rst_score", 32'(score), 0);
      check_value("rst_kill", 32'(kill), 0);
      check_value("rst_left", 32'(blocks_left), 0);
      check_value("rst_flags", 32'({level_clear, game_over, step_down, bounce_x, bounce_y}), 0);

      reset = 1'b0;
      tick();
      check_value("idle_state", 32'(state), 0);
      check_value("idle_left", 32'(blocks_left), 4);

      // Free-running descent: step every 4th RUN cycle
      start = 1'b1;
      tick();
      check_value("run_enter", 32'(state), 1);
      for (int i = 1; i <= 12; i++) begin
         tick();
         check_value("step_period", 32'(step_down), 32'(i % 4 == 0));
      end
      check_value("run_left", 32'(blocks_left), 4);

      // Two simultaneous left hits: only block 1 granted
      hit_l = 4'b0110;
      tick();
      hit_l = '0;
      check_value("hit_state", 32'(state), 2);
      check_value("hit_kill", 32'(kill), 32'h2);
      check_value("hit_bx", 32'(bounce_x), 1);
      check_value("hit_by", 32'(bounce_y), 0);
      check_value("hit_score", 32'(score), 10);
      tick();
      check_value("cool_state", 32'(state), 3);
      check_value("cool_kill", 32'(kill), 0);
      repeat (3) pulse_ball();
      check_value("cool_hold", 32'(state), 3);
      pulse_ball();
      check_value("cool_exit", 32'(state), 1);

      // Corner hit on block 0, then hits ignored during cooldown
      hit_u = 4'b0001; hit_l = 4'b0001;
      tick();
      hit_u = '0; hit_l = '0;
      check_value("corner_kill", 32'(kill), 32'h1);
      check_value("corner_bxy", 32'({bounce_x, bounce_y}), 32'h3);
      check_value("corner_score", 32'(score), 20);
      tick();
      hit_d = 4'hF;
      tick(); tick();
      check_value("cool_ign_state", 32'(state), 3);
      check_value("cool_ign_kill", 32'(kill), 0);
      check_value("cool_ign_score", 32'(score), 20);
      hit_d = '0;
      repeat (4) pulse_ball();
      check_value("cool2_exit", 32'(state), 1);

      // Hit on a dead block is never granted
      exist = 4'b1011; hit_r = 4'b0100;
      tick();
      hit_r = '0;
      check_value("masked_state", 32'(state), 1);
      check_value("masked_kill", 32'(kill), 0);
      exist = 4'hF;

      // Reset while in HIT
      hit_u = 4'b1000;
      tick();
      hit_u = '0;
      check_value("hit3_state", 32'(state), 2);
      check_value("hit3_score", 32'(score), 30);
      reset = 1'b1;
      tick();
      check_value("rst_hit_kill", 32'(kill), 0);
      check_value("rst_hit_score", 32'(score), 0);
      check_value("rst_hit_state", 32'(state), 0);
      reset = 1'b0;

      // Pause keeps prescaler phase: RUN 3 cycles (count reaches 3), pause, resume
      tick(); tick(); tick();
      start = 1'b0;
      tick();
      check_value("pause_state", 32'(state), 0);
      repeat (5) tick();
      check_value("pause_step", 32'(step_down), 0);
      start = 1'b1;
      tick();
      check_value("resume_state", 32'(state), 1);
      check_value("resume_nostep", 32'(step_down), 0);
      tick();
      check_value("resume_step", 32'(step_down), 1);

      // Floor reached together with a hit: OVER wins, no kill
      at_bottom = 4'b1000; hit_d = 4'b0010;
      tick();
      at_bottom = '0; hit_d = '0;
      check_value("over_state", 32'(state), 5);
      check_value("over_flag", 32'(game_over), 1);
      check_value("over_kill", 32'(kill), 0);
      start = 1'b0;
      repeat (3) tick();
      check_value("over_hold", 32'(state), 5);
      check_value("over_score", 32'(score), 0);
      reset = 1'b1;
      tick();
      check_value("over_rst", 32'({game_over, state}), 0);

      // Clear the whole field
      start = 1'b1;
      reset = 1'b0;
      tick();
      for (int b = 0; b < 4; b++) begin
         hit_u = 4'(1 << b);
         tick();
         hit_u = '0;
         check_value("clr_kill", 32'(kill), 32'(1 << b));
         exist[b] = 1'b0;
         tick();
         repeat (4) pulse_ball();
         check_value("clr_state", 32'(state), (b == 3) ? 4 : 1);
      end
      check_value("clr_flag", 32'(level_clear), 1);
      check_value("clr_score", 32'(score), 40);
      check_value("clr_left", 32'(blocks_left), 0);
      repeat (3) tick();
      check_value("clr_hold", 32'({level_clear, state}), 32'hC);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
